// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter
//   Iterative shift-and-add-3 binary to packed-BCD converter that handles one
//   operand bit per clock. Operands that do not fit in DIGITS decimal digits
//   are saturated to all nines and flagged on ovf_o.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. The producer holds bin_i/valid_i until it is accepted.
//   The converter holds bcd_o/ovf_o/valid_o until ready_i takes the result.
//   Every output is either a flop or a pure decode of the state flop.
module bin2bcd_converter #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [BIN_WIDTH-1:0]  bin_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o
);

    localparam int BCD_W = 4 * DIGITS;
    // The counter only has to reach BIN_WIDTH-1.
    localparam int CNT_W = $clog2(BIN_WIDTH);

    // The largest value that fits in DIGITS decimal digits, evaluated at elaboration.
    function automatic longint unsigned max_decimal(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned MAX_DEC = max_decimal(DIGITS);
    localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{4'h9}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]           state_q,    state_d;
    logic [BIN_WIDTH-1:0] bin_q,      bin_d;
    logic [BCD_W-1:0]     scratch_q,  scratch_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]     bcd_q,      bcd_d;
    logic                 ovf_q,      ovf_d;

    logic [BCD_W-1:0]     scratch_adj;
    logic [BCD_W-1:0]     scratch_shift;
    logic [BIN_WIDTH-1:0] bin_shift;
    logic                 ovf_in;

    // One shift-and-add-3 step. Each digit is adjusted on its own with no
    // carry into the next digit, and the bit shifted out of the top digit is
    // dropped. That bit only matters for operands that get saturated anyway.
    always_comb begin
        scratch_adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
        scratch_shift = {scratch_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_shift     = {bin_q[BIN_WIDTH-2:0], 1'b0};
    end

    // Range check on the incoming operand. This check is constant-false
    // when every BIN_WIDTH-bit value fits in DIGITS digits.
    always_comb begin
        ovf_in = 64'(bin_i) > MAX_DEC;
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    bin_d      = bin_i;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = ovf_in;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = scratch_shift;
                bin_d     = bin_shift;
                cnt_d     = cnt_q + CNT_W'(1);
                // The last iteration publishes its own shifted value directly.
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    bcd_d   = ovf_pend_q ? SAT_BCD : scratch_shift;
                    ovf_d   = ovf_pend_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The result registers are left untouched and keep their value after the handshake.
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything and aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    // Output decode. These signals depend only on flops, never on inputs.
    always_comb begin
        ready_o = (state_q == ST_IDLE);
        valid_o = (state_q == ST_DONE);
        busy_o  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        bcd_o   = bcd_q;
        ovf_o   = ovf_q;
    end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Bench for bin2bcd_converter (BIN_WIDTH=14, DIGITS=4). It uses directed
// corner operands, a mid-operation reset, a back-to-back pair and a random
// sweep with random result backpressure. Expected results come from a
// decimal reference model.
module tb_bin2bcd_converter;

    logic        clk_i;
    logic        rst_ni;
    logic [13:0] bin_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] bcd_o;
    logic        ovf_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;

    int n_chk;
    int n_err;

    bin2bcd_converter #(
        .BIN_WIDTH (14),
        .DIGITS    (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bin_i   (bin_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .bcd_o   (bcd_o),
        .ovf_o   (ovf_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    // Clock and reset block.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic do_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        bin_i   = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. It splits the value into decimal digits with plain
    // arithmetic and saturates values above 9999.
    function automatic void model(input int unsigned v, output logic [15:0] b, output logic o);
        int unsigned t;
        t = v;
        o = (v > 9999);
        b = 16'h0000;
        if (o) begin
            b = 16'h9999;
        end else begin
            for (int i = 0; i < 4; i++) begin
                b[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
    endfunction

    // Driver. This task sends one operand and waits for the result.
    // It holds ready_i low for `hold` cycles in DONE and then completes
    // the handshake. It checks latency, stability and the hand-back to IDLE.
    task automatic run_op(input logic [13:0] v, input int hold);
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        int          k;
        model(32'(v), exp_bcd, exp_ovf);
        k = 0;
        @(negedge clk_i);
        while (!ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        check("ready_before_accept", 32'(ready_o), 32'd1);
        ready_i = 1'b0;
        bin_i   = v;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            k = c;
            bin_i = 14'($urandom_range(16383, 0));
            if (c == 7) begin
                check("busy_in_shift", 32'(busy_o), 32'd1);
                check("ready_in_shift", 32'(ready_o), 32'd0);
            end
            if (valid_o) break;
        end
        check("latency", 32'(k), 32'd15);
        check("busy_in_done", 32'(busy_o), 32'd1);
        check("ready_in_done", 32'(ready_o), 32'd0);
        check("bcd", 32'(bcd_o), 32'(exp_bcd));
        check("ovf", 32'(ovf_o), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            valid_i = 1'($urandom_range(1, 0));
            bin_i   = 14'($urandom_range(16383, 0));
            @(negedge clk_i);
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_bcd", 32'(bcd_o), 32'(exp_bcd));
            check("hold_ovf", 32'(ovf_o), 32'(exp_ovf));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("post_valid", 32'(valid_o), 32'd0);
        check("post_ready", 32'(ready_o), 32'd1);
        check("post_bcd_kept", 32'(bcd_o), 32'(exp_bcd));
        check("post_ovf_kept", 32'(ovf_o), 32'(exp_ovf));
    endtask

    // Watchdog.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard for the back-to-back pair.
    logic [15:0] exp_q[$];

    initial begin
        int          idx;
        int          nres;
        int          t_res[2];
        logic [15:0] r_bcd[2];
        logic [13:0] ops[2];
        n_chk = 0;
        n_err = 0;

        do_reset();
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_bcd", 32'(bcd_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);

        run_op(14'd0, 0);
        run_op(14'd1234, 5);
        run_op(14'd9999, 1);
        run_op(14'd10000, 0);
        run_op(14'd16383, 2);

        // Reset during SHIFT iteration 7. The result of the previous operand
        // (9999, ovf) is still showing, so clearing it is observable.
        @(negedge clk_i);
        bin_i   = 14'd1234;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_bcd", 32'(bcd_o), 32'd0);
        check("abort_ovf", 32'(ovf_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        check("abort_no_result", 32'(valid_o), 32'd0);
        run_op(14'd77, 0);

        // Back-to-back operands with ready_i held high.
        ops[0]   = 14'd42;
        ops[1]   = 14'd805;
        exp_q.push_back(16'h0042);
        exp_q.push_back(16'h0805);
        t_res[0] = 0;
        t_res[1] = 0;
        r_bcd[0] = '0;
        r_bcd[1] = '0;
        idx      = 0;
        nres     = 0;
        ready_i  = 1'b1;
        valid_i  = 1'b0;
        for (int k = 0; k < 80 && nres < 2; k++) begin
            @(negedge clk_i);
            if (valid_o) begin
                t_res[nres] = k;
                r_bcd[nres] = bcd_o;
                nres++;
            end
            if (ready_o && idx < 2) begin
                bin_i   = ops[idx];
                valid_i = 1'b1;
                idx++;
            end else if (ready_o) begin
                valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        ready_i = 1'b0;
        valid_i = 1'b0;
        check("b2b_count", 32'(nres), 32'd2);
        for (int r = 0; r < 2; r++) begin
            check("b2b_bcd", 32'(r_bcd[r]), 32'(exp_q.pop_front()));
        end
        check("b2b_gap", 32'(t_res[1] - t_res[0]), 32'd16);

        // Random sweep with random backpressure.
        for (int n = 0; n < 40; n++) begin
            run_op(14'($urandom_range(16383, 0)), int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
